nios_freq_meter: RTL and testbench

Avalon-MM slave that measures the frequency of an external digital signal by counting its rising edges over a programmable gate window of system clocks. It sits beside the interval timer on the Nios display system bus, with the same 16-bit register interface style. It delivers a latched 32-bit edge count per window for the display firmware and raises an interrupt when a result is ready.

---
 rtl/nios_freq_meter_pkg.sv | 25 ++
 rtl/freq_meter_edge_sync.sv | 28 ++
 rtl/nios_freq_meter.sv | 139 +++++++++++++
 tb/tb_nios_freq_meter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/nios_freq_meter_pkg.sv
// Shared constants and types for the Nios frequency meter: register map,
// status/control bit positions and the measurement FSM state type.
package nios_freq_meter_pkg;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_GATE_L   = 3'd2;
    localparam logic [2:0] ADDR_GATE_H   = 3'd3;
    localparam logic [2:0] ADDR_RESULT_L = 3'd4;
    localparam logic [2:0] ADDR_RESULT_H = 3'd5;

    localparam int STAT_READY   = 0;
    localparam int STAT_OVERRUN = 1;
    localparam int STAT_RUNNING = 2;

    localparam int CTRL_IEN = 0;
    localparam int CTRL_RUN = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        GATE = 2'd2
    } state_t;

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Synchronizes an asynchronous input into clk and emits a one-cycle pulse
// for each rising edge seen after synchronization.
module freq_meter_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_in,
    output logic edge_pulse
);

    logic [STAGES-1:0] sync;
    logic              sync_d;

    // Pulse is registered so a rise on sig_in is visible STAGES+1 edges later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync       <= '0;
            sync_d     <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            sync       <= {sync[STAGES-2:0], sig_in};
            sync_d     <= sync[STAGES-1];
            edge_pulse <= sync[STAGES-1] & ~sync_d;
        end
    end

endmodule

// File: rtl/nios_freq_meter.sv
// Avalon-MM frequency meter: counts sig_in rising edges over a programmable
// gate window of clk cycles and latches the count for firmware with an irq.
module nios_freq_meter
    import nios_freq_meter_pkg::*;
#(
    parameter logic [31:0] GATE_RESET  = 32'd50_000_000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    input  logic        sig_in,
    output logic        irq,
    output logic [15:0] readdata
);

    state_t      state, state_d;
    logic        ien, run, ready, overrun;
    logic [31:0] gate_reg, gate_cnt, edge_cnt, result;
    logic        sig_edge;

    freq_meter_edge_sync #(.STAGES(SYNC_STAGES)) u_edge_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .sig_in     (sig_in),
        .edge_pulse (sig_edge)
    );

    logic        wr_en, running, win_end, ready_eff, overrun_eff;
    logic [31:0] gate_load, edge_total;

    assign wr_en       = chipselect & ~write_n;
    assign running     = (state != IDLE);
    assign win_end     = (state == GATE) && run && (gate_cnt == 32'd1);
    assign gate_load   = (gate_reg == 32'd0) ? 32'd1 : gate_reg;
    assign edge_total  = (edge_cnt == 32'hFFFF_FFFF) ? edge_cnt : edge_cnt + {31'd0, sig_edge};
    // A STATUS write clears first, so a coincident window end still latches.
    assign ready_eff   = ready & ~(wr_en && address == ADDR_STATUS);
    assign overrun_eff = overrun & ~(wr_en && address == ADDR_STATUS);
    assign irq         = ready & ien;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (run) state_d = ARM;
            ARM:     state_d = GATE;
            GATE:    if (!run) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    // Window end reloads immediately so consecutive windows have no dead time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
        end else begin
            case (state)
                ARM: begin
                    gate_cnt <= gate_load;
                    edge_cnt <= '0;
                end
                GATE: begin
                    if (!run) begin
                        edge_cnt <= '0;
                    end else if (gate_cnt == 32'd1) begin
                        gate_cnt <= gate_load;
                        edge_cnt <= '0;
                    end else begin
                        gate_cnt <= gate_cnt - 32'd1;
                        edge_cnt <= edge_total;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready   <= 1'b0;
            overrun <= 1'b0;
            result  <= '0;
        end else if (win_end && !ready_eff) begin
            result  <= edge_total;
            ready   <= 1'b1;
            overrun <= overrun_eff;
        end else if (win_end) begin
            ready   <= ready_eff;
            overrun <= 1'b1;
        end else begin
            ready   <= ready_eff;
            overrun <= overrun_eff;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ien      <= 1'b0;
            run      <= 1'b0;
            gate_reg <= GATE_RESET;
        end else if (wr_en) begin
            case (address)
                ADDR_CONTROL: begin
                    ien <= writedata[CTRL_IEN];
                    run <= writedata[CTRL_RUN];
                end
                ADDR_GATE_L: gate_reg[15:0]  <= writedata;
                ADDR_GATE_H: gate_reg[31:16] <= writedata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                ADDR_STATUS:   readdata <= {13'd0, running, overrun, ready};
                ADDR_CONTROL:  readdata <= {14'd0, run, ien};
                ADDR_GATE_L:   readdata <= gate_reg[15:0];
                ADDR_GATE_H:   readdata <= gate_reg[31:16];
                ADDR_RESULT_L: readdata <= result[15:0];
                ADDR_RESULT_H: readdata <= result[31:16];
                default:       readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_nios_freq_meter.sv
// Self-checking bench for nios_freq_meter: register reset table, window
// measurement, overrun, abort, terminal-cycle edge, clk/2 rate and gate 0.
module tb_nios_freq_meter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic        sig_in = 1'b0;
    logic        irq;
    logic [15:0] readdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    int   half = 0;
    int   ph = 0;
    logic sig_level = 1'b0;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[8];

    nios_freq_meter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .sig_in     (sig_in),
        .irq        (irq),
        .readdata   (readdata)
    );

    always #5 clk = ~clk;

    // half==0 holds sig_in at sig_level; otherwise toggle every half cycles
    always @(negedge clk) begin
        if (half == 0) begin
            sig_in = sig_level;
            ph = 0;
        end else if (ph >= half - 1) begin
            sig_in = ~sig_in;
            ph = 0;
        end else begin
            ph++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
        exp_q.push_back(exp);
        @(negedge clk);
        address = a;
        @(posedge clk);
        #1;
        check(name, readdata, exp_q.pop_front());
    endtask

    task automatic wait_irq(input int max_cyc, input string name);
        bit seen = 0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(posedge clk);
            #1;
            if (irq) seen = 1;
        end
        check(name, seen, 1);
    endtask

    task automatic run_reset_table(input string tag);
        for (int i = 0; i < 8; i++)
            rd(tbl[i].addr, tbl[i].exp, $sformatf("%s_addr%0d", tag, tbl[i].addr));
    endtask

    task automatic stop_and_clear();
        wr(3'd1, 16'h0001);
        wr(3'd0, 16'h0000);
    endtask

    initial begin
        tbl[0] = '{3'd0, 16'h0000};
        tbl[1] = '{3'd1, 16'h0000};
        tbl[2] = '{3'd2, 16'hF080};
        tbl[3] = '{3'd3, 16'h02FA};
        tbl[4] = '{3'd4, 16'h0000};
        tbl[5] = '{3'd5, 16'h0000};
        tbl[6] = '{3'd6, 16'h0000};
        tbl[7] = '{3'd7, 16'h0000};

        repeat (3) @(posedge clk);
        #1;
        check("reset_readdata", readdata, 0);
        check("reset_irq", irq, 0);
        @(negedge clk);
        reset_n = 1'b1;
        run_reset_table("reset");

        // Gate 100, period 10: ready exactly 102 cycles after the run write
        wr(3'd2, 16'd100);
        wr(3'd3, 16'd0);
        half = 5;
        wr(3'd1, 16'h0003);
        repeat (101) @(posedge clk);
        #1;
        check("main_irq_before_end", irq, 0);
        @(posedge clk);
        #1;
        check("main_irq_at_end", irq, 1);
        rd(3'd4, 16'd10, "main_result_l");
        rd(3'd5, 16'd0, "main_result_h");
        rd(3'd0, 16'h0005, "main_status");
        rd(3'd1, 16'h0003, "main_control");
        wr(3'd0, 16'h0000);
        check("main_irq_cleared", irq, 0);

        // Overrun: window 1 latches 5, later windows (10 edges) must not tear it
        stop_and_clear();
        half = 10;
        wr(3'd1, 16'h0003);
        wait_irq(150, "ovr_first_ready");
        rd(3'd4, 16'd5, "ovr_first_result");
        half = 5;
        repeat (250) @(posedge clk);
        rd(3'd0, 16'h0007, "ovr_status");
        rd(3'd4, 16'd5, "ovr_result_held");
        wr(3'd0, 16'h0000);
        wait_irq(150, "ovr_relatch_ready");
        rd(3'd4, 16'd10, "ovr_relatch_result");
        rd(3'd0, 16'h0005, "ovr_relatch_status");

        // Abort mid-window: no latch, RESULT keeps 10
        stop_and_clear();
        half = 10;
        wr(3'd1, 16'h0003);
        repeat (50) @(posedge clk);
        wr(3'd1, 16'h0001);
        repeat (120) @(posedge clk);
        #1;
        check("abort_irq", irq, 0);
        rd(3'd0, 16'h0000, "abort_status");
        rd(3'd4, 16'd10, "abort_result");

        // Single edge reaching the counter on the terminal cycle of a 10-cycle gate
        stop_and_clear();
        half = 0;
        sig_level = 1'b0;
        wr(3'd2, 16'd10);
        wr(3'd1, 16'h0003);
        repeat (8) @(posedge clk);
        @(negedge clk);
        sig_level = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("term_irq_before_end", irq, 0);
        @(posedge clk);
        #1;
        check("term_irq_at_end", irq, 1);
        rd(3'd4, 16'd1, "term_window1_result");
        wr(3'd0, 16'h0000);
        repeat (10) @(posedge clk);
        #1;
        check("term_window2_ready", irq, 1);
        rd(3'd4, 16'd0, "term_window2_result");
        sig_level = 1'b0;

        // clk/2 input over a 1000-cycle gate
        stop_and_clear();
        wr(3'd2, 16'd1000);
        half = 1;
        wr(3'd1, 16'h0003);
        wait_irq(1100, "fast_ready");
        rd(3'd4, 16'd500, "fast_result_l");
        rd(3'd5, 16'd0, "fast_result_h");

        // Reset asserted while running
        repeat (30) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset_readdata", readdata, 0);
        check("midreset_irq", irq, 0);
        half = 0;
        sig_level = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        run_reset_table("midreset");

        // Gate 0 behaves as a 1-cycle window
        wr(3'd2, 16'd0);
        wr(3'd3, 16'd0);
        wr(3'd1, 16'h0003);
        repeat (2) @(posedge clk);
        #1;
        check("gate0_irq_before_end", irq, 0);
        @(posedge clk);
        #1;
        check("gate0_irq_at_end", irq, 1);
        rd(3'd4, 16'd0, "gate0_result");
        rd(3'd0, 16'h0007, "gate0_status");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
